// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: buffers AXI-Stream DAC samples in a small FIFO and
// releases one sample every CLK_DIV clocks, substituting midscale on underflow.
module dac_sample_pacer #(
    parameter int         C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int         FIFO_DEPTH             = 16,
    parameter int         PRIME_LEVEL            = 8,
    parameter int         CLK_DIV                = 2500,
    parameter logic [7:0] MIDSCALE               = 8'h80
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    output logic                              s00_axis_tready,
    input  logic                              enable,
    output logic [7:0]                        dac_data,
    output logic                              dac_strobe,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic [15:0]                       underflow_count,
    output logic                              running
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_PRIME = (AW+1)'(PRIME_LEVEL);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t        state;
    logic [DW-1:0] divider;
    logic          rst_done;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          push;
    logic          pop;
    logic          tick;
    logic          fifo_empty;

    // tlast and the upper data bits carry nothing for this block
    logic unused_axis;
    assign unused_axis = ^{s00_axis_tlast,
                           s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:8]};

    // tready stays low for one cycle after reset release
    assign s00_axis_tready = rst_done && (fifo_level != LVL_FULL);
    assign push            = s00_axis_tvalid && s00_axis_tready;
    assign fifo_empty      = (fifo_level == '0);

    // a tick only exists in RUN; disabling on a tick cycle wins over the pop
    assign tick = (state == ST_RUN) && (divider == DIV_LAST);
    assign pop  = tick && enable && !fifo_empty;

    // one-cycle post-reset hold-off for the input handshake
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // sample storage; contents are don't-care until written
    always_ff @(posedge s00_axis_aclk) begin
        if (push) begin
            mem[wr_ptr] <= s00_axis_tdata[7:0];
        end
    end

    // FIFO pointers wrap naturally at the power-of-two depth
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // pacing FSM: owns the divider and every registered DAC-side output
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state           <= ST_IDLE;
            divider         <= '0;
            dac_data        <= MIDSCALE;
            dac_strobe      <= 1'b0;
            underflow_count <= '0;
            running         <= 1'b0;
        end else begin
            dac_strobe <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    divider  <= '0;
                    running  <= 1'b0;
                    dac_data <= MIDSCALE;
                    if (enable) begin
                        state <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    divider <= '0;
                    if (!enable) begin
                        state      <= ST_IDLE;
                        running    <= 1'b0;
                        dac_data   <= MIDSCALE;
                        dac_strobe <= (dac_data != MIDSCALE);
                    end else if (fifo_level >= LVL_PRIME) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state      <= ST_IDLE;
                        running    <= 1'b0;
                        divider    <= '0;
                        dac_data   <= MIDSCALE;
                        dac_strobe <= (dac_data != MIDSCALE);
                    end else if (tick) begin
                        divider    <= '0;
                        dac_strobe <= 1'b1;
                        if (fifo_empty) begin
                            // starved: emit midscale and wait to re-prime
                            dac_data <= MIDSCALE;
                            state    <= ST_PRIME;
                            running  <= 1'b0;
                            if (underflow_count != 16'hFFFF) begin
                                underflow_count <= underflow_count + 16'd1;
                            end
                        end else begin
                            dac_data <= mem[rd_ptr];
                        end
                    end else begin
                        divider <= divider + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    divider <= '0;
                end
            endcase
        end
    end

endmodule
